uart_tx_word: RTL and testbench

- Transmit-side counterpart of the word-oriented UART receiver.
- Accepts 32-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word as four 8N1 UART frames on txd: byte 0 = wdata[7:0] first, each byte LSB first.
- Sits between the core's output path and the board TX pin. It must interoperate bit-exactly with the receiver at the same CLK_PER_HALF_BIT.

---
 rtl/uart_tx_word_pkg.sv | 17 +
 rtl/uart_tx_word_fifo.sv | 63 ++++++
 rtl/uart_tx_word.sv | 129 ++++++++++++
 tb/tb_uart_tx_word.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_word_pkg.sv
// Shared types and constants for the word-oriented UART transmit path.
//   tx_state_e     : serialiser states
//   BYTES_PER_WORD : bytes per 32-bit word on the line
//   DATA_BITS      : data bits per 8N1 frame
//   bit_clks()     : full bit period from the half-bit clock count
package uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = 8;

  function automatic int bit_clks(input int half);
    return 2 * half;
  endfunction

endpackage

// File: rtl/uart_tx_word_fifo.sv
// word_fifo: synchronous FIFO with registered pointers and an occupancy count.
//   clk, rstn      : clock, synchronous active-low reset
//   push, wdata    : write request and data (ignored while full)
//   pop, rdata     : read request; rdata shows the head entry combinationally
//   full, empty    : status from the occupancy at the start of the cycle
// Push and pop in the same cycle are both honoured. Because full is taken
// from the registered count, a pop never frees a slot for a same-cycle push.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_word.sv
// uart_tx_word: buffers 32-bit words and sends each as four 8N1 frames,
// byte 0 (wdata[7:0]) first, every byte LSB first.
//   clk, rstn          : clock, synchronous active-low reset
//   wdata, wdata_valid : word to send; accepted when wdata_ready is high
//   wdata_ready        : FIFO not full
//   txd                : registered serial line, idle high
//   busy               : frame in flight or words still queued
module uart_tx_word #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic        txd,
  output logic        busy
);
  import uart_pkg::*;

  localparam int BIT_CLKS = bit_clks(CLK_PER_HALF_BIT);
  localparam int CW       = $clog2(BIT_CLKS);

  tx_state_e   state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shreg_q, shreg_d;
  logic        txd_q, txd_d;
  logic        pop, bit_end;
  logic [31:0] fifo_rdata;
  logic        fifo_full, fifo_empty;

  word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wdata_valid),
    .wdata (wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wdata_ready = !fifo_full;
  assign busy        = (state_q != TX_IDLE) || !fifo_empty;
  assign txd         = txd_q;
  assign bit_end     = (bit_cnt_q == CW'(BIT_CLKS - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = fifo_rdata;
          byte_idx_d = '0;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = TX_STOP;
          else                                bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      TX_STOP: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
            state_d = TX_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = TX_START;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // txd is decoded from the current state and registered, so the line trails
  // the FSM by one clock; every level still lasts exactly BIT_CLKS clocks.
  always_comb begin
    unique case (state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shreg_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= TX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word: a fast instance (half bit = 4 clocks) for
// function, burst and reset cases, and a full-rate instance (half bit = 434)
// for line timing. A bench-side receiver samples txd at mid-bit.
module tb_uart_tx_word;

  localparam int B    = 8;          // bit period, fast instance
  localparam int WGAP = 40 * B + 1; // start-to-start for back-to-back words
  localparam int B_L  = 868;        // bit period, full-rate instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [31:0] wdata, wdata_l;
  logic        wdata_valid, valid_l;
  logic        wdata_ready, txd, busy;
  logic        ready_l, txd_l, busy_l;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  uart_tx_word #(.CLK_PER_HALF_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .wdata(wdata), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .txd(txd), .busy(busy)
  );

  uart_tx_word #(.CLK_PER_HALF_BIT(434), .FIFO_DEPTH(4)) dut_l (
    .clk(clk), .rstn(rstn), .wdata(wdata_l), .wdata_valid(valid_l),
    .wdata_ready(ready_l), .txd(txd_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic line(input bit slow);
    return slow ? txd_l : txd;
  endfunction

  // Push one word; p is the cycle index of the accepting edge.
  task automatic push(input bit slow, input logic [31:0] d, output int p);
    @(negedge clk);
    if (slow) begin wdata_l = d; valid_l = 1'b1; end
    else      begin wdata = d;   wdata_valid = 1'b1; end
    @(posedge clk);
    #1;
    p = cyc;
    valid_l = 1'b0; wdata_valid = 1'b0;
    wdata_l = '0;   wdata = '0;
  endtask

  // Receive one word at mid-bit. t_fall is the first sample showing the start
  // bit; ok drops on a bad start/stop bit or any gap between bytes.
  task automatic rx_word(input bit slow, output logic [31:0] w, output int t_fall,
                         output bit ok);
    int bc = slow ? B_L : B;
    int n  = 0;
    w = '0; ok = 1'b1; t_fall = -1;
    @(negedge clk);
    while (line(slow) !== 1'b0 && n < 45 * bc) begin
      @(negedge clk);
      n++;
    end
    if (line(slow) !== 1'b0) begin
      chk("rx_start_found", {31'd0, line(slow)}, 32'd0);
      ok = 1'b0;
      return;
    end
    t_fall = cyc;
    for (int by = 0; by < 4; by++) begin
      if (by > 0) begin
        repeat (bc / 2) @(negedge clk);
        if (line(slow) !== 1'b0) ok = 1'b0;
      end
      repeat (bc / 2) @(negedge clk);
      if (line(slow) !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (bc) @(negedge clk);
        w[by*8+i] = line(slow);
      end
      repeat (bc) @(negedge clk);
      if (line(slow) !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          p, t, t0;
    bit          ok;
    logic [31:0] bw [8];
    int          acc [8];

    rstn = 1'b0; wdata = '0; wdata_valid = 1'b0; wdata_l = '0; valid_l = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, wdata_ready}, 32'd1);
    chk("rst_txd_l", {31'd0, txd_l}, 32'd1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single word: start bit two clocks after the accepting edge.
    push(1'b0, 32'h4433_2211, p);
    chk("single_busy_queued", {31'd0, busy}, 32'd1);
    rx_word(1'b0, w, t, ok);
    chk("single_word", w, 32'h4433_2211);
    chk("single_frame", {31'd0, ok}, 32'd1);
    chk("single_latency", t - p, 32'd2);
    // FSM leaves IDLE at p+1 and returns 320 clocks later.
    wait_cyc(p + 320);
    chk("single_busy_last", {31'd0, busy}, 32'd1);
    wait_cyc(p + 321);
    chk("single_busy_end", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Burst of 8 words with valid held.
    bw = '{32'h0102_0304, 32'hA0B0_C0D0, 32'h1111_1111, 32'hFEDC_BA98,
           32'h0000_00FF, 32'h8000_0001, 32'h5A5A_A5A5, 32'h7654_3210};
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          int n = 0;
          wdata = bw[k];
          wdata_valid = 1'b1;
          while (!wdata_ready && n < 1000) begin
            @(negedge clk);
            n++;
          end
          @(posedge clk);
          #1;
          acc[k] = cyc;
          chk($sformatf("burst_ready_%0d", k), {31'd0, wdata_ready},
              (k >= 4) ? 32'd0 : 32'd1);
        end
        wdata_valid = 1'b0;
        wdata = '0;
      end
      begin
        int tf [8];
        for (int k = 0; k < 8; k++) begin
          rx_word(1'b0, w, tf[k], ok);
          chk($sformatf("burst_word_%0d", k), w, bw[k]);
          chk($sformatf("burst_frame_%0d", k), {31'd0, ok}, 32'd1);
          if (k > 0) chk($sformatf("burst_gap_%0d", k), tf[k] - tf[k-1], WGAP);
        end
        chk("burst_first_latency", tf[0] - acc[0], 32'd2);
      end
    join
    for (int k = 1; k < 8; k++)
      chk($sformatf("burst_accept_t%0d", k), acc[k] - acc[0],
          (k <= 4) ? k : 2 + (k - 4) * WGAP);
    repeat (5) @(negedge clk);

    // Reset during bit 3 of byte 1 (a zero bit of 0xA5).
    push(1'b0, 32'hA5A5_A5A5, p);
    t0 = p + 2;
    wait_cyc(t0 + 14 * B + 3);
    chk("mid_pre_txd", {31'd0, txd}, 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", {31'd0, txd}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, wdata_ready}, 32'd1);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    push(1'b0, 32'h1234_5678, p);
    rx_word(1'b0, w, t, ok);
    chk("mid_after_word", w, 32'h1234_5678);
    chk("mid_after_frame", {31'd0, ok}, 32'd1);
    chk("mid_after_latency", t - p, 32'd2);

    // Full-rate line timing with 0x55555555 (a transition on every bit).
    begin
      int n = 0, ntr = 1, bad = 0, last = 0;
      logic prev, b_hi, b_lo;
      b_hi = 1'b0; b_lo = 1'b1;
      push(1'b1, 32'h5555_5555, p);
      while (txd_l !== 1'b0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("tmg_start_found", {31'd0, txd_l}, 32'd0);
      t0 = cyc;
      chk("tmg_latency", t0 - p, 32'd2);
      prev = 1'b0;
      for (int k = 1; k <= 40 * B_L + 4; k++) begin
        @(negedge clk);
        if (txd_l !== prev) begin
          ntr++;
          if (((cyc - t0) % B_L) != 0) bad++;
          last = cyc - t0;
          prev = txd_l;
        end
        if (cyc == t0 + 40 * B_L - 2) b_hi = busy_l;
        if (cyc == t0 + 40 * B_L - 1) b_lo = busy_l;
      end
      chk("tmg_misaligned", bad, 32'd0);
      chk("tmg_edges", ntr, 32'd40);
      chk("tmg_last_edge", last, 39 * B_L);
      chk("tmg_end_txd", {31'd0, txd_l}, 32'd1);
      chk("tmg_busy_last", {31'd0, b_hi}, 32'd1);
      chk("tmg_busy_end", {31'd0, b_lo}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
